// File: rtl/up_down_sequencer.sv
// Up/down count controller with a run-gated prescaler tick, parallel load and
// wrap-or-halt handling at the count limits.
module up_down_sequencer #(
  parameter int COUNT_WIDTH = 4,
  parameter int DIV_WIDTH   = 25,
  parameter int DIV_MAX     = 6000000 - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   dir_toggle,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   wrap_en,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   dir,
  output logic                   running,
  output logic                   tick,
  output logic                   limit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0]   DIV_TERM  = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_TOP = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_BOT = {COUNT_WIDTH{1'b0}};

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [DIV_WIDTH-1:0]     presc_q, presc_d;
  logic                     dir_q;
  logic                     limit_q, limit_d;
  logic                     at_limit;

  assign tick     = (state_q == RUN) && (presc_q == DIV_TERM);
  assign at_limit = dir_q ? (count_q == COUNT_BOT) : (count_q == COUNT_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= COUNT_BOT;
      presc_q <= '0;
      dir_q   <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      limit_q <= limit_d;
      if (dir_toggle) dir_q <= ~dir_q;
    end
  end

  // Commands are prioritised load > stop > start; a tick only acts when no
  // command claims the cycle, so a coinciding load/stop discards it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = 1'b0;
    presc_d = '0;
    if (load) begin
      count_d = load_value;
      state_d = IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (tick) begin
            if (at_limit) begin
              limit_d = 1'b1;
              if (wrap_en) count_d = dir_q ? COUNT_TOP : COUNT_BOT;
              else         state_d = HALT;
            end else begin
              count_d = dir_q ? (count_q - COUNT_ONE) : (count_q + COUNT_ONE);
            end
          end
        end
        HALT: if (dir_toggle) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    // The prescaler only runs while staying in RUN, so every entry starts at 0.
    if (state_q == RUN && state_d == RUN)
      presc_d = tick ? '0 : (presc_q + DIV_ONE);
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign running = (state_q == RUN);
  assign limit   = limit_q;

endmodule
